ptw_axi_arbiter: RTL and testbench
==================================

# ptw_axi_arbiter

Shares the single page-table-walk AXI read master between the instruction-TLB walker and the data-TLB walker. Each walker issues one-cycle PTE read pulses and waits for one 64-bit PTE. The arbiter captures both requests, grants one at a time, forwards the address to the AXI master and routes the returned PTE back to the owner. It sits between both TLB walkers and the AXI master.

## Interface
Parameters:
- ADDR_WIDTH, 64, PTE address width
- DATA_WIDTH, 64, PTE width

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- I_REQ_VALID  in  1  ITLB walker request pulse (one cycle)
- I_REQ_ADDR  in  ADDR_WIDTH  ITLB PTE address, valid with pulse
- I_RESP_VALID  out  1  one-cycle PTE return to ITLB
- I_RESP_DATA  out  DATA_WIDTH  PTE to ITLB
- D_REQ_VALID / D_REQ_ADDR / D_RESP_VALID / D_RESP_DATA  same as I_*, for DTLB walker
- M_ADDR_VALID  out  1  address valid to AXI master; held until accepted
- M_ADDR_READY  in  1  AXI master accepts address
- M_ADDR  out  ADDR_WIDTH  granted PTE address
- M_DATA_VALID  in  1  PTE returned (one cycle)
- M_DATA  in  DATA_WIDTH  returned PTE
- BUSY  out  1  state != IDLE
- OWNER  out  1  0 = ITLB, 1 = DTLB; meaningful while BUSY
- PROTO_ERR  out  1  sticky protocol-violation flag

## Operation
- Per requester, a pending slot holds {valid, addr}. The slot is set on REQ_VALID and cleared when granted.
- FSM states:
  - IDLE: if any slot is valid, pick the winner, latch M_ADDR and OWNER, clear the winner's slot, go to ISSUE.
  - ISSUE: M_ADDR_VALID=1. On M_ADDR_READY, go to WAIT.
  - WAIT: on M_DATA_VALID, register M_DATA into the owner's RESP_DATA, pulse the owner's RESP_VALID, go to IDLE.
- Default arbitration is fixed priority: DTLB beats ITLB.
- Only one transaction is outstanding at any time.
- Boundary conditions:
  - REQ_VALID while that requester's slot is already valid: request dropped, PROTO_ERR set.
  - REQ_VALID from the current owner during ISSUE or WAIT: legal, because its slot was cleared at grant.
  - M_DATA_VALID in IDLE or ISSUE: ignored, PROTO_ERR set.
  - M_ADDR_READY outside ISSUE: ignored.
  - Both requests arriving in the same cycle: both captured; the winner is served first and the loser is granted in the next IDLE.
- RST mid-transaction returns the FSM to IDLE and clears both slots, and with them any pending request. A late M_DATA_VALID after reset sets PROTO_ERR and is not forwarded.
- PROTO_ERR clears only on RST.

## Timing
- Reset values: M_ADDR_VALID=0, M_ADDR=0, I/D_RESP_VALID=0, I/D_RESP_DATA=0, BUSY=0, OWNER=0, PROTO_ERR=0.
- Request pulse in cycle t (arbiter idle): slot valid in t+1, M_ADDR_VALID high from t+2.
- M_ADDR_READY in cycle a with M_ADDR_VALID high: handshake completes and M_ADDR_VALID is low from a+1.
- M_DATA_VALID in cycle k: owner RESP_VALID high in k+1 only, RESP_DATA valid in k+1, FSM in IDLE in k+1. The next M_ADDR_VALID comes no earlier than k+2.
- M_ADDR is stable while M_ADDR_VALID is high.
- Back-to-back service of both walkers costs at least 3 cycles of arbiter overhead per PTE.

## Configuration
- PTW_ARB_RR_EN defined: round-robin arbitration. A last-owner register is updated at each grant and reset to DTLB, so ITLB wins the first tie and ties then alternate.
- PTW_ARB_RR_EN undefined: fixed priority, DTLB over ITLB, and there is no last-owner register.

## Structure
- Package ptw_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT}
  - owner constants OWN_I=1'b0, OWN_D=1'b1
  - default width constants
- Sub-module ptw_req_slot is the capture register with set/clear/overflow-error output. It is instantiated once per requester.

## Test plan
- ITLB pulse with addr 0x8000_1000, M_ADDR_READY tied 1, M_DATA 0x2000_00CF three cycles later -> M_ADDR 0x8000_1000 at t+2; I_RESP_VALID one cycle with 0x2000_00CF; D_RESP_VALID stays 0.
- I and D pulse in the same cycle (0x100, 0x200), fixed priority -> DTLB served first (0x200), then ITLB (0x100); with PTW_ARB_RR_EN, ITLB first, and on a second tie DTLB first.
- M_ADDR_READY held low 5 cycles -> M_ADDR_VALID high and M_ADDR stable for all 5 cycles, then deasserts the cycle after READY.
- Second ITLB pulse while I slot is pending -> PROTO_ERR=1 and only one M_ADDR issued; a spurious M_DATA_VALID in IDLE also sets PROTO_ERR and produces no RESP pulse.
- RST asserted during WAIT, then M_DATA_VALID -> all outputs at reset values, no RESP_VALID, PROTO_ERR=1.

Source files
------------

// File: rtl/ptw_arb_pkg.sv
// Shared types and constants for the page-table-walk AXI read arbiter.
// Round-robin arbitration is selected by defining PTW_ARB_RR_EN.
package ptw_arb_pkg;

  localparam int PTW_ADDR_W = 64;
  localparam int PTW_DATA_W = 64;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ptw_arb_state_e;

  // Winner among the pending slots. On a tie, round-robin hands the grant to
  // whoever did not own the bus last; fixed priority always prefers DTLB.
  function automatic logic pick_owner(input logic i_pend, input logic d_pend,
                                      input logic rr, input logic last_owner);
    if (i_pend && d_pend) begin
      return rr ? ~last_owner : OWN_D;
    end
    return d_pend ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/ptw_req_slot.sv
// One pending-request slot: captures a walker's PTE address until granted.
// A pulse arriving while the slot is still occupied is dropped and flagged.
module ptw_req_slot
  import ptw_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = PTW_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  set,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  overflow
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (set && !valid_q) begin
      valid_q <= 1'b1;
      addr_q  <= set_addr;
    end else if (clr) begin
      valid_q <= 1'b0;
    end
  end

  assign valid    = valid_q;
  assign addr     = addr_q;
  assign overflow = set && valid_q;

endmodule

// File: rtl/ptw_axi_arbiter.sv
// Shares the PTW AXI read master between the ITLB and DTLB walkers, one
// transaction at a time. Define PTW_ARB_RR_EN for round-robin tie-breaking.
module ptw_axi_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = PTW_ADDR_W,
  parameter int DATA_WIDTH = PTW_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] I_REQ_ADDR,
  output logic                  I_RESP_VALID,
  output logic [DATA_WIDTH-1:0] I_RESP_DATA,
  input  logic                  D_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] D_REQ_ADDR,
  output logic                  D_RESP_VALID,
  output logic [DATA_WIDTH-1:0] D_RESP_DATA,
  output logic                  M_ADDR_VALID,
  input  logic                  M_ADDR_READY,
  output logic [ADDR_WIDTH-1:0] M_ADDR,
  input  logic                  M_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  BUSY,
  output logic                  OWNER,
  output logic                  PROTO_ERR
);

  // Address channel: M_ADDR_VALID is raised only in ISSUE and, once raised,
  // stays high with M_ADDR frozen until the cycle M_ADDR_READY is seen high;
  // the transfer happens on that edge and M_ADDR_VALID drops on the next.

  ptw_arb_state_e        state_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic                  owner_q;
  logic                  i_resp_valid_q;
  logic                  d_resp_valid_q;
  logic [DATA_WIDTH-1:0] i_resp_data_q;
  logic [DATA_WIDTH-1:0] d_resp_data_q;
  logic                  proto_err_q;

  logic                  i_pend;
  logic                  d_pend;
  logic [ADDR_WIDTH-1:0] i_pend_addr;
  logic [ADDR_WIDTH-1:0] d_pend_addr;
  logic                  i_ovf;
  logic                  d_ovf;
  logic                  grant_any;
  logic                  grant_own;
  logic                  grant_i;
  logic                  grant_d;
  logic                  last_owner;
  logic                  rr_mode;

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_i_slot (
    .CLK      (CLK),
    .RST      (RST),
    .set      (I_REQ_VALID),
    .set_addr (I_REQ_ADDR),
    .clr      (grant_i),
    .valid    (i_pend),
    .addr     (i_pend_addr),
    .overflow (i_ovf)
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_d_slot (
    .CLK      (CLK),
    .RST      (RST),
    .set      (D_REQ_VALID),
    .set_addr (D_REQ_ADDR),
    .clr      (grant_d),
    .valid    (d_pend),
    .addr     (d_pend_addr),
    .overflow (d_ovf)
  );

`ifdef PTW_ARB_RR_EN
  logic last_owner_q;

  // Starts at DTLB so the first tie after reset goes to the ITLB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_owner_q <= OWN_D;
    end else if (grant_any) begin
      last_owner_q <= grant_own;
    end
  end

  assign last_owner = last_owner_q;
  assign rr_mode    = 1'b1;
`else
  assign last_owner = OWN_D;
  assign rr_mode    = 1'b0;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_own = OWN_I;
    if (state_q == IDLE && (i_pend || d_pend)) begin
      grant_any = 1'b1;
      grant_own = pick_owner(i_pend, d_pend, rr_mode, last_owner);
    end
  end

  assign grant_i = grant_any && (grant_own == OWN_I);
  assign grant_d = grant_any && (grant_own == OWN_D);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      m_addr_q       <= '0;
      owner_q        <= OWN_I;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_data_q  <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            m_addr_q <= (grant_own == OWN_D) ? d_pend_addr : i_pend_addr;
            owner_q  <= grant_own;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (M_ADDR_READY) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (M_DATA_VALID) begin
            if (owner_q == OWN_D) begin
              d_resp_valid_q <= 1'b1;
              d_resp_data_q  <= M_DATA;
            end else begin
              i_resp_valid_q <= 1'b1;
              i_resp_data_q  <= M_DATA;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Data with no address outstanding (including a reply that straddled
      // a reset) is never forwarded, only recorded.
      if (i_ovf || d_ovf || (M_DATA_VALID && state_q != WAIT)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign M_ADDR_VALID = (state_q == ISSUE);
  assign M_ADDR       = m_addr_q;
  assign BUSY         = (state_q != IDLE);
  assign OWNER        = owner_q;
  assign I_RESP_VALID = i_resp_valid_q;
  assign I_RESP_DATA  = i_resp_data_q;
  assign D_RESP_VALID = d_resp_valid_q;
  assign D_RESP_DATA  = d_resp_data_q;
  assign PROTO_ERR    = proto_err_q;

  a_addr_stable: assert property (@(posedge CLK) disable iff (RST)
    (M_ADDR_VALID && !M_ADDR_READY) |=> (M_ADDR_VALID && $stable(M_ADDR)));

  a_one_resp: assert property (@(posedge CLK) disable iff (RST)
    !(I_RESP_VALID && D_RESP_VALID));

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// Directed bench for ptw_axi_arbiter; inputs change and outputs are checked
// on the falling edge, so each step() is one arbiter cycle.
module tb_ptw_axi_arbiter;

  logic        CLK;
  logic        RST;
  logic        I_REQ_VALID;
  logic [63:0] I_REQ_ADDR;
  logic        I_RESP_VALID;
  logic [63:0] I_RESP_DATA;
  logic        D_REQ_VALID;
  logic [63:0] D_REQ_ADDR;
  logic        D_RESP_VALID;
  logic [63:0] D_RESP_DATA;
  logic        M_ADDR_VALID;
  logic        M_ADDR_READY;
  logic [63:0] M_ADDR;
  logic        M_DATA_VALID;
  logic [63:0] M_DATA;
  logic        BUSY;
  logic        OWNER;
  logic        PROTO_ERR;

  int total;
  int bad;

  ptw_axi_arbiter dut (
    .CLK          (CLK),
    .RST          (RST),
    .I_REQ_VALID  (I_REQ_VALID),
    .I_REQ_ADDR   (I_REQ_ADDR),
    .I_RESP_VALID (I_RESP_VALID),
    .I_RESP_DATA  (I_RESP_DATA),
    .D_REQ_VALID  (D_REQ_VALID),
    .D_REQ_ADDR   (D_REQ_ADDR),
    .D_RESP_VALID (D_RESP_VALID),
    .D_RESP_DATA  (D_RESP_DATA),
    .M_ADDR_VALID (M_ADDR_VALID),
    .M_ADDR_READY (M_ADDR_READY),
    .M_ADDR       (M_ADDR),
    .M_DATA_VALID (M_DATA_VALID),
    .M_DATA       (M_DATA),
    .BUSY         (BUSY),
    .OWNER        (OWNER),
    .PROTO_ERR    (PROTO_ERR)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    I_REQ_VALID = 1'b0; I_REQ_ADDR = '0;
    D_REQ_VALID = 1'b0; D_REQ_ADDR = '0;
    M_ADDR_READY = 1'b0; M_DATA_VALID = 1'b0; M_DATA = '0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // Drives one granted transaction to completion and checks routing.
  task automatic serve(input logic [63:0] exp_addr, input logic exp_own,
                       input logic [63:0] pte, input string tag);
    int n;
    n = 0;
    while (M_ADDR_VALID !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (M_ADDR_VALID !== 1'b1) begin
      bad++;
      $display("FAIL %s_issue: M_ADDR_VALID=%b want 1 within 20 cycles", tag, M_ADDR_VALID);
      return;
    end
    total++;
    if (M_ADDR !== exp_addr) begin
      bad++; $display("FAIL %s_addr: M_ADDR=%h want %h", tag, M_ADDR, exp_addr);
    end
    total++;
    if (OWNER !== exp_own || BUSY !== 1'b1) begin
      bad++; $display("FAIL %s_owner: OWNER=%b BUSY=%b want %b 1", tag, OWNER, BUSY, exp_own);
    end
    M_ADDR_READY = 1'b1;
    step();
    M_ADDR_READY = 1'b0;
    total++;
    if (M_ADDR_VALID !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL %s_wait: M_ADDR_VALID=%b BUSY=%b want 0 1", tag, M_ADDR_VALID, BUSY);
    end
    M_DATA_VALID = 1'b1;
    M_DATA = pte;
    step();
    M_DATA_VALID = 1'b0;
    M_DATA = '0;
    total++;
    if (exp_own == 1'b0) begin
      if (I_RESP_VALID !== 1'b1 || I_RESP_DATA !== pte || D_RESP_VALID !== 1'b0) begin
        bad++;
        $display("FAIL %s_resp: I_RESP_VALID=%b I_RESP_DATA=%h D_RESP_VALID=%b want 1 %h 0",
                 tag, I_RESP_VALID, I_RESP_DATA, D_RESP_VALID, pte);
      end
    end else begin
      if (D_RESP_VALID !== 1'b1 || D_RESP_DATA !== pte || I_RESP_VALID !== 1'b0) begin
        bad++;
        $display("FAIL %s_resp: D_RESP_VALID=%b D_RESP_DATA=%h I_RESP_VALID=%b want 1 %h 0",
                 tag, D_RESP_VALID, D_RESP_DATA, I_RESP_VALID, pte);
      end
    end
    total++;
    if (BUSY !== 1'b0 || M_ADDR_VALID !== 1'b0) begin
      bad++; $display("FAIL %s_idle: BUSY=%b M_ADDR_VALID=%b want 0 0", tag, BUSY, M_ADDR_VALID);
    end
    step();
    total++;
    if (I_RESP_VALID !== 1'b0 || D_RESP_VALID !== 1'b0) begin
      bad++; $display("FAIL %s_pulse: I_RESP_VALID=%b D_RESP_VALID=%b want 0 0",
                      tag, I_RESP_VALID, D_RESP_VALID);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (M_ADDR_VALID !== 1'b0 || M_ADDR !== 64'h0 || I_RESP_VALID !== 1'b0 ||
        D_RESP_VALID !== 1'b0 || I_RESP_DATA !== 64'h0 || D_RESP_DATA !== 64'h0 ||
        BUSY !== 1'b0 || OWNER !== 1'b0 || PROTO_ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: mav=%b ma=%h irv=%b drv=%b ird=%h drd=%h busy=%b own=%b perr=%b want all 0",
               M_ADDR_VALID, M_ADDR, I_RESP_VALID, D_RESP_VALID, I_RESP_DATA, D_RESP_DATA,
               BUSY, OWNER, PROTO_ERR);
    end
  endtask

  task automatic test_single_itlb();
    M_ADDR_READY = 1'b1;
    I_REQ_VALID = 1'b1;
    I_REQ_ADDR = 64'h8000_1000;
    step();
    I_REQ_VALID = 1'b0;
    I_REQ_ADDR = '0;
    total++;
    if (M_ADDR_VALID !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL single_t1: M_ADDR_VALID=%b BUSY=%b want 0 0", M_ADDR_VALID, BUSY);
    end
    step();
    total++;
    if (M_ADDR_VALID !== 1'b1 || M_ADDR !== 64'h8000_1000) begin
      bad++; $display("FAIL single_t2: M_ADDR_VALID=%b M_ADDR=%h want 1 8000_1000", M_ADDR_VALID, M_ADDR);
    end
    serve(64'h8000_1000, 1'b0, 64'h2000_00CF, "single");
    total++;
    if (D_RESP_VALID !== 1'b0 || D_RESP_DATA !== 64'h0 || PROTO_ERR !== 1'b0) begin
      bad++; $display("FAIL single_dside: D_RESP_VALID=%b D_RESP_DATA=%h PROTO_ERR=%b want 0 0 0",
                      D_RESP_VALID, D_RESP_DATA, PROTO_ERR);
    end
  endtask

  task automatic test_tie();
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h100;
    D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h200;
    step();
    I_REQ_VALID = 1'b0; D_REQ_VALID = 1'b0;
`ifdef PTW_ARB_RR_EN
    serve(64'h100, 1'b0, 64'hAAAA_0001, "tie1_first");
    serve(64'h200, 1'b1, 64'hAAAA_0002, "tie1_second");
`else
    serve(64'h200, 1'b1, 64'hAAAA_0002, "tie1_first");
    serve(64'h100, 1'b0, 64'hAAAA_0001, "tie1_second");
`endif
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h180;
    step();
    I_REQ_VALID = 1'b0;
    serve(64'h180, 1'b0, 64'hAAAA_0003, "tie_single");
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h110;
    D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h210;
    step();
    I_REQ_VALID = 1'b0; D_REQ_VALID = 1'b0;
    serve(64'h210, 1'b1, 64'hAAAA_0004, "tie2_first");
    serve(64'h110, 1'b0, 64'hAAAA_0005, "tie2_second");
    total++;
    if (PROTO_ERR !== 1'b0) begin
      bad++; $display("FAIL tie_perr: PROTO_ERR=%b want 0", PROTO_ERR);
    end
  endtask

  task automatic test_owner_rerequest();
    D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h400;
    step();
    D_REQ_VALID = 1'b0;
    step();
    total++;
    if (M_ADDR_VALID !== 1'b1 || M_ADDR !== 64'h400) begin
      bad++; $display("FAIL rereq_issue: M_ADDR_VALID=%b M_ADDR=%h want 1 400", M_ADDR_VALID, M_ADDR);
    end
    M_ADDR_READY = 1'b1;
    D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h480;
    step();
    M_ADDR_READY = 1'b0;
    D_REQ_VALID = 1'b0;
    M_DATA_VALID = 1'b1; M_DATA = 64'hDDDD_0400;
    step();
    M_DATA_VALID = 1'b0; M_DATA = '0;
    total++;
    if (D_RESP_VALID !== 1'b1 || D_RESP_DATA !== 64'hDDDD_0400 || PROTO_ERR !== 1'b0) begin
      bad++; $display("FAIL rereq_resp: D_RESP_VALID=%b D_RESP_DATA=%h PROTO_ERR=%b want 1 dddd_0400 0",
                      D_RESP_VALID, D_RESP_DATA, PROTO_ERR);
    end
    serve(64'h480, 1'b1, 64'hDDDD_0480, "rereq_second");
    total++;
    if (PROTO_ERR !== 1'b0) begin
      bad++; $display("FAIL rereq_perr: PROTO_ERR=%b want 0", PROTO_ERR);
    end
  endtask

  task automatic test_backpressure();
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h5000;
    step();
    I_REQ_VALID = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (M_ADDR_VALID !== 1'b1 || M_ADDR !== 64'h5000) begin
        bad++; $display("FAIL bp_hold%0d: M_ADDR_VALID=%b M_ADDR=%h want 1 5000", i, M_ADDR_VALID, M_ADDR);
      end
      step();
    end
    M_ADDR_READY = 1'b1;
    step();
    M_ADDR_READY = 1'b0;
    total++;
    if (M_ADDR_VALID !== 1'b0) begin
      bad++; $display("FAIL bp_drop: M_ADDR_VALID=%b want 0", M_ADDR_VALID);
    end
    M_DATA_VALID = 1'b1; M_DATA = 64'h5555_0001;
    step();
    M_DATA_VALID = 1'b0; M_DATA = '0;
    total++;
    if (I_RESP_VALID !== 1'b1 || I_RESP_DATA !== 64'h5555_0001) begin
      bad++; $display("FAIL bp_resp: I_RESP_VALID=%b I_RESP_DATA=%h want 1 5555_0001", I_RESP_VALID, I_RESP_DATA);
    end
    step();
  endtask

  task automatic test_overflow();
    int issued;
    D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h300;
    step();
    D_REQ_VALID = 1'b0;
    step();
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'hA000;
    step();
    I_REQ_ADDR = 64'hB000;
    step();
    I_REQ_VALID = 1'b0; I_REQ_ADDR = '0;
    total++;
    if (PROTO_ERR !== 1'b1) begin
      bad++; $display("FAIL ovf_perr: PROTO_ERR=%b want 1", PROTO_ERR);
    end
    serve(64'h300, 1'b1, 64'hEEEE_0300, "ovf_d");
    serve(64'hA000, 1'b0, 64'hEEEE_A000, "ovf_i");
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      if (M_ADDR_VALID === 1'b1) issued++;
      step();
    end
    total++;
    if (issued != 0) begin
      bad++; $display("FAIL ovf_extra: extra M_ADDR_VALID cycles=%0d want 0", issued);
    end
  endtask

  task automatic test_spurious_data();
    do_reset();
    total++;
    if (PROTO_ERR !== 1'b0) begin
      bad++; $display("FAIL spur_clear: PROTO_ERR=%b want 0", PROTO_ERR);
    end
    M_DATA_VALID = 1'b1; M_DATA = 64'hBAD0_0001;
    step();
    M_DATA_VALID = 1'b0; M_DATA = '0;
    total++;
    if (PROTO_ERR !== 1'b1 || I_RESP_VALID !== 1'b0 || D_RESP_VALID !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL spur_data: PROTO_ERR=%b I_RESP_VALID=%b D_RESP_VALID=%b BUSY=%b want 1 0 0 0",
                      PROTO_ERR, I_RESP_VALID, D_RESP_VALID, BUSY);
    end
    step();
    step();
    total++;
    if (PROTO_ERR !== 1'b1) begin
      bad++; $display("FAIL spur_sticky: PROTO_ERR=%b want 1", PROTO_ERR);
    end
  endtask

  task automatic test_reset_mid_wait();
    int issued;
    do_reset();
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h7000;
    step();
    I_REQ_VALID = 1'b0;
    step();
    M_ADDR_READY = 1'b1;
    step();
    M_ADDR_READY = 1'b0;
    total++;
    if (BUSY !== 1'b1 || M_ADDR_VALID !== 1'b0) begin
      bad++; $display("FAIL rstw_wait: BUSY=%b M_ADDR_VALID=%b want 1 0", BUSY, M_ADDR_VALID);
    end
    D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h7800;
    step();
    D_REQ_VALID = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++;
    if (M_ADDR_VALID !== 1'b0 || M_ADDR !== 64'h0 || BUSY !== 1'b0 || OWNER !== 1'b0 ||
        PROTO_ERR !== 1'b0 || I_RESP_VALID !== 1'b0 || D_RESP_VALID !== 1'b0) begin
      bad++; $display("FAIL rstw_reset: mav=%b ma=%h busy=%b own=%b perr=%b irv=%b drv=%b want all 0",
                      M_ADDR_VALID, M_ADDR, BUSY, OWNER, PROTO_ERR, I_RESP_VALID, D_RESP_VALID);
    end
    M_DATA_VALID = 1'b1; M_DATA = 64'h7777_0001;
    step();
    M_DATA_VALID = 1'b0; M_DATA = '0;
    total++;
    if (I_RESP_VALID !== 1'b0 || D_RESP_VALID !== 1'b0 || I_RESP_DATA !== 64'h0 ||
        D_RESP_DATA !== 64'h0 || PROTO_ERR !== 1'b1 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rstw_late: irv=%b drv=%b ird=%h drd=%h perr=%b busy=%b want 0 0 0 0 1 0",
                      I_RESP_VALID, D_RESP_VALID, I_RESP_DATA, D_RESP_DATA, PROTO_ERR, BUSY);
    end
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      if (M_ADDR_VALID === 1'b1) issued++;
      step();
    end
    total++;
    if (issued != 0) begin
      bad++; $display("FAIL rstw_slots: M_ADDR_VALID cycles after reset=%0d want 0", issued);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST = 1'b1;
    I_REQ_VALID = 1'b0; I_REQ_ADDR = '0;
    D_REQ_VALID = 1'b0; D_REQ_ADDR = '0;
    M_ADDR_READY = 1'b0; M_DATA_VALID = 1'b0; M_DATA = '0;
    test_reset();
    test_single_itlb();
    test_tie();
    test_owner_rerequest();
    test_backpressure();
    test_overflow();
    test_spurious_data();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
